// File: rtl/picture_uart_sender_if.sv
// Port bundle for the picture upload path: control handshake, BRAM read port and serial line.
interface picture_uart_sender_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [18:0] r_address;
  logic [17:0] r_data;
  logic        uart_tx;

  modport master (output start, r_data, input busy, done, r_address, uart_tx);
  modport slave  (input start, r_data, output busy, done, r_address, uart_tx);
endinterface

// File: rtl/picture_uart_sender.sv
// Streams the picture BRAM out over UART 8N1, three bytes per pixel ({colour,2'b00}), raster order.
module picture_uart_sender #(
  parameter int PIXELS       = 276185,
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  picture_uart_sender_if.slave  bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int WW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, TX_START, TX_DATA, TX_STOP, DONE} state_t;

  state_t          state, state_nxt;
  logic [18:0]     pix;
  logic [17:0]     hold;
  logic [CW-1:0]   clk_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      cur_byte;
  logic            bit_end, wait_end, last_pix, tx_nxt;

  assign bit_end  = (clk_cnt == CW'(CPB - 1));
  assign wait_end = (wait_cnt == WW'(READ_LATENCY - 1));
  assign last_pix = (pix == 19'(PIXELS - 1));

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = {hold[17:12], 2'b00};
      2'd1:    cur_byte = {hold[11:6], 2'b00};
      default: cur_byte = {hold[5:0], 2'b00};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // uart_tx is registered from the current state, so the line lags the FSM by one clock.
  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      IDLE:     if (bus.start) state_nxt = FETCH;
      FETCH:    state_nxt = WAIT;
      WAIT:     if (wait_end) state_nxt = TX_START;
      TX_START: begin
        tx_nxt = 1'b0;
        if (bit_end) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_nxt = cur_byte[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (byte_idx != 2'd2) state_nxt = TX_START;
          else if (last_pix)    state_nxt = DONE;
          else                  state_nxt = FETCH;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.uart_tx   <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.r_address <= '0;
      pix           <= '0;
      hold          <= '0;
      clk_cnt       <= '0;
      wait_cnt      <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
    end else begin
      bus.uart_tx <= tx_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.done      <= 1'b0;
            bus.busy      <= 1'b1;
            pix           <= '0;
            bus.r_address <= '0;
          end
        end
        FETCH: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (wait_end) hold <= bus.r_data;
        end
        TX_START, TX_DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (state == TX_DATA && bit_end) bit_idx <= bit_idx + 1'b1;
        end
        TX_STOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (byte_idx != 2'd2) byte_idx <= byte_idx + 1'b1;
            else if (!last_pix) begin
              // address for the next pixel is presented while in FETCH
              pix           <= pix + 19'd1;
              bus.r_address <= pix + 19'd1;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_picture_uart_sender.sv
// Directed bench: two senders (4-pixel and 1-pixel frames) behind a 2-clock BRAM model, decoded by a UART monitor.
module tb_picture_uart_sender;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  picture_uart_sender_if ifa();
  picture_uart_sender_if ifb();

  picture_uart_sender #(.PIXELS(4), .CLK_FREQ(100), .BAUD(10), .READ_LATENCY(2))
    u_dut4 (.clk(clk), .reset(reset), .bus(ifa));
  picture_uart_sender #(.PIXELS(1), .CLK_FREQ(100), .BAUD(10), .READ_LATENCY(2))
    u_dut1 (.clk(clk), .reset(reset), .bus(ifb));

  // BRAM models with two clocks of read latency
  logic [17:0] mema [4];
  logic [17:0] d1a, d1b;
  initial for (int i = 0; i < 4; i++) mema[i] = {6'(i + 1), 6'(2 * i), 6'h15};
  always @(posedge clk) begin
    d1a        <= mema[ifa.r_address[1:0]];
    ifa.r_data <= d1a;
    d1b        <= (ifb.r_address == 19'd0) ? 18'h3F000 : 18'h0;
    ifb.r_data <= d1b;
  end

  logic [7:0] exp4 [12] = '{8'h04, 8'h00, 8'h54, 8'h08, 8'h08, 8'h54,
                            8'h0C, 8'h10, 8'h54, 8'h10, 8'h18, 8'h54};
  logic [7:0] exp1 [3]  = '{8'hFC, 8'h00, 8'h00};

  typedef struct {
    logic [7:0]  data;
    int          ts;
    logic [18:0] ra;
    logic        stop;
  } rx_t;
  rx_t qa[$], qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic tx_of(input int w);
    return (w == 0) ? ifa.uart_tx : ifb.uart_tx;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? ifa.busy : ifb.busy;
  endfunction

  // samples each bit at its centre; bytes cut short by reset are dropped
  task automatic mon(input int w);
    rx_t  r;
    logic ok;
    forever begin
      @(negedge clk);
      if (reset && tx_of(w) == 1'b0) begin
        r.ts   = cyc;
        r.ra   = (w == 0) ? ifa.r_address : ifb.r_address;
        r.data = '0;
        r.stop = 1'b0;
        ok     = 1'b1;
        for (int j = 0; j < 9 && ok; j++) begin
          for (int k = 0; k < ((j == 0) ? 15 : 10) && ok; k++) begin
            @(negedge clk);
            if (!reset) ok = 1'b0;
          end
          if (ok) begin
            if (j < 8) r.data[j] = tx_of(w);
            else       r.stop    = tx_of(w);
          end
        end
        if (ok) begin
          if (w == 0) qa.push_back(r);
          else        qb.push_back(r);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic pulse(input int w, output int a);
    @(negedge clk);
    if (w == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge clk);
    if (w == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
    a = cyc;
  endtask

  task automatic wait_done(input int w, input int a, input int exp_off);
    int t;
    t = -1;
    for (int i = 0; i < 4000 && t < 0; i++) begin
      @(negedge clk);
      if (done_of(w)) t = cyc;
    end
    chk("done_time", t - a, exp_off);
    chk("busy_at_done", busy_of(w), 1'b0);
  endtask

  task automatic check_frame(input int w, input int a, input int np);
    rx_t q[$];
    int  n, p, b;
    if (w == 0) q = qa; else q = qb;
    chk("nbytes", q.size(), 3 * np);
    n = (q.size() < 3 * np) ? q.size() : 3 * np;
    for (int i = 0; i < n; i++) begin
      p = i / 3;
      b = i % 3;
      chk("byte", q[i].data, (w == 0) ? exp4[i] : exp1[i]);
      chk("byte_time", q[i].ts - a, 4 + p * 303 + b * 100);
      chk("r_address", q[i].ra, p);
      chk("stop_bit", q[i].stop, 1'b1);
    end
  endtask

  initial begin
    int a;
    reset     = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    // reset held while start toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_tx", ifa.uart_tx, 1'b1);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_done", ifa.done, 1'b0);
      chk("rst_addr", ifa.r_address, 19'd0);
      ifa.start = ~ifa.start;
      ifb.start = ~ifb.start;
    end
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    // single pixel frame
    qb.delete();
    pulse(1, a);
    chk("busy_set1", ifb.busy, 1'b1);
    wait_done(1, a, 304);
    check_frame(1, a, 1);

    // full four-pixel frame
    qa.delete();
    pulse(0, a);
    chk("busy_set", ifa.busy, 1'b1);
    wait_done(0, a, 1213);
    check_frame(0, a, 4);

    // restart from done=1, with a stray start pulse mid-frame
    chk("done_sticky", ifa.done, 1'b1);
    qa.delete();
    pulse(0, a);
    chk("done_clr", ifa.done, 1'b0);
    chk("busy_restart", ifa.busy, 1'b1);
    repeat (500) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, a, 1213);
    check_frame(0, a, 4);

    // reset during data bit 4 of byte1 (pixel 0 G byte = 00, so the line is low)
    qa.delete();
    pulse(0, a);
    while (cyc < a + 158) @(negedge clk);
    chk("bit4_low", ifa.uart_tx, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("abort_tx", ifa.uart_tx, 1'b1);
    chk("abort_busy", ifa.busy, 1'b0);
    chk("abort_addr", ifa.r_address, 19'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    qa.delete();
    pulse(0, a);
    wait_done(0, a, 1213);
    check_frame(0, a, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
